// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch redirect flush,
// data-memory wait stall, and halt drain/freeze sequencing for a
// classic five-stage in-order pipeline.
module hazard_ctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_uses_rs1_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_mem_read_en_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_redirect_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             halt_req_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_stall_o,
  output logic             ex_mem_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cycles_o
);

  // Drain counter must hold DRAIN_CYC; keep at least one bit.
  localparam int unsigned DRN_W_RAW = $clog2(DRAIN_CYC + 1);
  localparam int unsigned DRN_W     = (DRN_W_RAW < 1) ? 1 : DRN_W_RAW;
  localparam logic [DRN_W-1:0] DRN_LOAD = DRN_W'(DRAIN_CYC);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_DRAIN    = 2'd2,
    S_HALTED   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               ret_drain_q, ret_drain_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               halted_q;

  // Raw (pre-reset-gating) control outputs.
  logic pc_stall_raw, if_id_stall_raw, id_ex_stall_raw, ex_mem_stall_raw;
  logic if_id_flush_raw, id_ex_flush_raw;

  logic mem_wait;
  logic rs1_hit, rs2_hit, load_use;

  // Hazard detection terms.
  always_comb begin
    mem_wait = mem_req_i & ~mem_ready_i;
    rs1_hit  = id_uses_rs1_i & (id_rs1_addr_i == ex_rd_addr_i);
    rs2_hit  = id_uses_rs2_i & (id_rs2_addr_i == ex_rd_addr_i);
    load_use = ex_mem_read_en_i & (ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);
  end

  // Next-state, drain counter and raw stall/flush decode.
  always_comb begin
    state_d         = state_q;
    ret_drain_d     = ret_drain_q;
    drain_d         = drain_q;
    pc_stall_raw    = 1'b0;
    if_id_stall_raw = 1'b0;
    id_ex_stall_raw = 1'b0;
    ex_mem_stall_raw = 1'b0;
    if_id_flush_raw = 1'b0;
    id_ex_flush_raw = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          pc_stall_raw     = 1'b1;
          if_id_stall_raw  = 1'b1;
          id_ex_stall_raw  = 1'b1;
          ex_mem_stall_raw = 1'b1;
          ret_drain_d      = 1'b0;
          state_d          = S_MEM_WAIT;
        end else if (ex_redirect_i) begin
          if_id_flush_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (load_use) begin
          pc_stall_raw    = 1'b1;
          if_id_stall_raw = 1'b1;
          id_ex_flush_raw = 1'b1;
        end else if (halt_req_i) begin
          drain_d = DRN_LOAD;
          state_d = S_DRAIN;
        end
      end

      S_MEM_WAIT: begin
        // Drain counter untouched here so a halt resumes where it left off.
        if (mem_wait) begin
          pc_stall_raw     = 1'b1;
          if_id_stall_raw  = 1'b1;
          id_ex_stall_raw  = 1'b1;
          ex_mem_stall_raw = 1'b1;
        end else begin
          state_d = ret_drain_q ? S_DRAIN : S_RUN;
        end
      end

      S_DRAIN: begin
        if (mem_wait) begin
          pc_stall_raw     = 1'b1;
          if_id_stall_raw  = 1'b1;
          id_ex_stall_raw  = 1'b1;
          ex_mem_stall_raw = 1'b1;
          ret_drain_d      = 1'b1;
          state_d          = S_MEM_WAIT;
        end else begin
          if (ex_redirect_i) begin
            // Let the PC take the branch target; restart the bubble count.
            if_id_flush_raw = 1'b1;
            id_ex_flush_raw = 1'b1;
            drain_d         = DRN_LOAD;
          end else begin
            pc_stall_raw    = 1'b1;
            if_id_flush_raw = 1'b1;
            drain_d         = (drain_q != '0) ? drain_q - DRN_W'(1) : '0;
            if (drain_q <= DRN_W'(1)) begin
              state_d = S_HALTED;
            end
          end
          // Halt withdrawn: back to normal issue, inserted bubbles stay.
          if (!halt_req_i) begin
            state_d = S_RUN;
          end
        end
      end

      S_HALTED: begin
        pc_stall_raw     = 1'b1;
        if_id_stall_raw  = 1'b1;
        id_ex_stall_raw  = 1'b1;
        ex_mem_stall_raw = 1'b1;
        if (!halt_req_i) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  // Control outputs are forced low while reset is asserted.
  always_comb begin
    pc_stall_o     = pc_stall_raw     & rst_n;
    if_id_stall_o  = if_id_stall_raw  & rst_n;
    id_ex_stall_o  = id_ex_stall_raw  & rst_n;
    ex_mem_stall_o = ex_mem_stall_raw & rst_n;
    if_id_flush_o  = if_id_flush_raw  & rst_n;
    id_ex_flush_o  = id_ex_flush_raw  & rst_n;
  end

  // Saturating count of PC stall cycles outside HALTED.
  always_comb begin
    cnt_d = cnt_q;
    if (pc_stall_o && (state_q != S_HALTED) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State, drain counter, stall counter and halted flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      ret_drain_q <= 1'b0;
      drain_q     <= '0;
      cnt_q       <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_drain_q <= ret_drain_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      halted_q    <= (state_d == S_HALTED);
    end
  end

  assign halted_o       = halted_q;
  assign stall_cycles_o = cnt_q;

endmodule
